rf_writeback_arbiter: RTL
=========================

// Module: rf_writeback_arbiter
// PURPOSE
//  Shares the register file's single write port (we3/ra3/wd3/selec_v_s_w/cmd) among NREQ writeback
//  sources (scalar ALU, vector ALU, load unit). Tracks pending writes per scalar/vector register
//  so issue logic can stall on RAW/WAW hazards. Sits between the execute/memory stages and the
//  register file.
// PARAMETERS
//  NREQ   3   number of writeback requesters (index 0 = scalar ALU)
//  LANES  16  vector lanes; lane LANES-1 carries the scalar value
//  DW     32  lane data width
//  AW     4   register address width (16 regs per bank)
//  CW     2   per-register pending-write counter width
// PORTS
//  clk             in   1            core clock; all state updates on posedge
//  rst             in   1            reset, asynchronous, active-high
//  req_valid       in   NREQ         requester i has a write beat
//  req_ready       out  NREQ         beat of requester i accepted this cycle (one-hot or 0)
//  req_addr        in   NREQ*AW      destination register
//  req_vec         in   NREQ         1 = vector-bank write path, 0 = scalar path
//  req_cmd         in   NREQ*3       command forwarded to the register file
//  req_data        in   NREQ*LANES*DW write data, lane-packed
//  rf_we           out  1            to regfile we3
//  rf_ra3          out  AW           to regfile ra3
//  rf_wd3          out  LANES*DW     to regfile wd3
//  rf_selec_v_s_w  out  1            to regfile selec_v_s_w
//  rf_cmd          out  3            to regfile cmd
//  alloc_valid     in   1            issue stage reserves a destination
//  alloc_addr      in   AW           reserved register
//  alloc_vec       in   1            reserved bank (1 = vector, 0 = scalar)
//  alloc_ready     out  1            0 when the addressed counter is saturated
//  busy_s          out  16           scalar reg has a pending write (counter != 0)
//  busy_v          out  16           vector reg has a pending write
//  sb_err          out  1            sticky: retire with counter already 0
// BEHAVIOUR
//  Reset: rf_we=0, rf_ra3=0, rf_wd3=0, rf_selec_v_s_w=0, rf_cmd=0, rr pointer=NREQ-1, all
//   counters 0, busy_s=busy_v=0, sb_err=0. Mid-operation reset drops the in-flight registered beat.
//  Arbitration: combinational round-robin over req_valid, starting at (ptr+1) mod NREQ.
//   req_ready = grant, one-hot. Zero or one beat is accepted per cycle. ptr <= granted index on accept.
//   A requester holds valid/addr/vec/cmd/data stable until ready. No drop or reorder within one requester.
//  Output stage: the accepted beat is registered on posedge. rf_* are valid for the whole next cycle,
//   so the regfile's negedge write samples stable values. Latency is 1 cycle from accept to rf_we=1.
//   rf_we=0 in any cycle that follows no accept. rf_wd3 holds its last value when idle.
//  Bank mapping for retire, applied at accept:
//   req_vec=0                 -> scalar counter[addr]
//   req_vec=1 & cmd==3'b101   -> scalar counter[addr]; the regfile writes lane 15 into the scalar bank
//   req_vec=1, otherwise      -> vector counter[addr]
//  Scoreboard counters (CW bits each, 16 scalar + 16 vector):
//   alloc && alloc_ready -> +1; retire -> -1; both on the same counter in the same cycle -> unchanged.
//   alloc_ready = (addressed counter != 2**CW-1), combinational.
//   alloc_valid with alloc_ready=0 is ignored; issue must stall.
//   Retire on a counter at 0 leaves it at 0 and sets sb_err (cleared only by rst).
//   busy_* come from registered counters; they update the cycle after alloc/retire.
//  Scalar r15 (PC) is never written through this port. Retire to scalar addr 15 still counts normally.
// CONFIGURATION
//  RF_WB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, ptr unused/held at reset value.
//  Not defined (default): round-robin as above. All other behaviour is identical.
// TESTING
//  1 Reset: assert rst mid-write -> next cycle rf_we=0, busy_s=busy_v=0, sb_err=0, alloc_ready=1.
//  2 Single beat: req0 valid, addr=3, vec=0, data lane15=0x1234 -> req_ready=001; next cycle
//    rf_we=1, rf_ra3=3, rf_selec_v_s_w=0, rf_wd3[15]=0x1234; cycle after that rf_we=0.
//  3 Round-robin: all three requesters valid for 6 cycles -> grants 0,1,2,0,1,2. With
//    RF_WB_FIXED_PRIO_EN -> grants 0,0,0,... while req0 stays valid.
//  4 Scoreboard: alloc v5 x3 -> busy_v[5]=1, alloc_ready=0 for v5; 4th alloc ignored; three vec
//    retires to 5 -> busy_v[5]=0; extra retire -> sb_err=1.
//  5 cmd 101: alloc scalar 7, vector req addr=7, cmd=3'b101 -> busy_s[7] clears, busy_v[7]
//    unchanged, rf_cmd=3'b101, rf_selec_v_s_w=1.
//  6 Same-cycle alloc+retire on s2 with counter=1 -> counter stays 1, busy_s[2] stays 1.

Source files
------------

// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter: shares the single write port among NREQ sources and keeps per-register pending-write counters.
// Define RF_WB_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.
module rf_writeback_arbiter #(
  parameter int NREQ  = 3,
  parameter int LANES = 16,
  parameter int DW    = 32,
  parameter int AW    = 4,
  parameter int CW    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*AW-1:0]          req_addr,
  input  logic [NREQ-1:0]             req_vec,
  input  logic [NREQ*3-1:0]           req_cmd,
  input  logic [NREQ*LANES*DW-1:0]    req_data,
  output logic                        rf_we,
  output logic [AW-1:0]               rf_ra3,
  output logic [LANES*DW-1:0]         rf_wd3,
  output logic                        rf_selec_v_s_w,
  output logic [2:0]                  rf_cmd,
  input  logic                        alloc_valid,
  input  logic [AW-1:0]               alloc_addr,
  input  logic                        alloc_vec,
  output logic                        alloc_ready,
  output logic [2**AW-1:0]            busy_s,
  output logic [2**AW-1:0]            busy_v,
  output logic                        sb_err
);

  localparam int              NREG    = 2**AW;
  localparam int              WW      = LANES*DW;
  localparam int              PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0]   PTR_RST = PW'(NREQ-1);
  localparam logic [CW-1:0]   CNT_MAX = '1;
  localparam logic [2:0]      CMD_V2S = 3'b101;

  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            accept;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
`ifdef RF_WB_FIXED_PRIO_EN
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = PW'(i);
      end
    end
  end
`else
  // Scan from farthest to nearest so the requester closest after ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        grant                          = '0;
        grant[(int'(ptr) + k) % NREQ]  = 1'b1;
        grant_idx                      = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end
`endif

  assign req_ready = grant;
  assign accept    = |grant;

  logic [AW-1:0]  sel_addr;
  logic           sel_vec;
  logic [2:0]     sel_cmd;
  logic [WW-1:0]  sel_data;
  logic           ret_vbank;

  assign sel_addr  = req_addr[int'(grant_idx)*AW +: AW];
  assign sel_vec   = req_vec[grant_idx];
  assign sel_cmd   = req_cmd[int'(grant_idx)*3 +: 3];
  assign sel_data  = req_data[int'(grant_idx)*WW +: WW];
  // A vector beat with cmd 101 lands lane 15 in the scalar bank, so it retires a scalar reservation.
  assign ret_vbank = sel_vec && (sel_cmd != CMD_V2S);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we          <= 1'b0;
      rf_ra3         <= '0;
      rf_wd3         <= '0;
      rf_selec_v_s_w <= 1'b0;
      rf_cmd         <= '0;
      ptr            <= PTR_RST;
    end else begin
      rf_we <= accept;
      if (accept) begin
        rf_ra3         <= sel_addr;
        rf_wd3         <= sel_data;
        rf_selec_v_s_w <= sel_vec;
        rf_cmd         <= sel_cmd;
`ifdef RF_WB_FIXED_PRIO_EN
        ptr            <= ptr;
`else
        ptr            <= grant_idx;
`endif
      end
    end
  end

  logic [CW-1:0] cnt_s [NREG];
  logic [CW-1:0] cnt_v [NREG];
  logic [CW-1:0] alloc_cnt;
  logic [CW-1:0] ret_cnt;
  logic          alloc_fire;
  logic          same_cnt;
  logic          underflow;
  logic [NREG-1:0] inc_s, inc_v, dec_s, dec_v;

  assign alloc_cnt   = alloc_vec ? cnt_v[alloc_addr] : cnt_s[alloc_addr];
  assign ret_cnt     = ret_vbank ? cnt_v[sel_addr]   : cnt_s[sel_addr];
  assign alloc_ready = (alloc_cnt != CNT_MAX);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign same_cnt    = alloc_fire && accept && (alloc_vec == ret_vbank) && (alloc_addr == sel_addr);
  // An alloc landing on the retiring counter cancels it, so that retire cannot underflow.
  assign underflow   = accept && (ret_cnt == '0) && !same_cnt;

  always_comb begin
    inc_s = '0;
    inc_v = '0;
    dec_s = '0;
    dec_v = '0;
    if (alloc_fire) begin
      if (alloc_vec) inc_v[alloc_addr] = 1'b1;
      else           inc_s[alloc_addr] = 1'b1;
    end
    if (accept) begin
      if (ret_vbank) dec_v[sel_addr] = 1'b1;
      else           dec_s[sel_addr] = 1'b1;
    end
  end

  // NOTE: the counter arrays are reset explicitly because busy_* must read 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_s[r] <= '0;
        cnt_v[r] <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_s[r] && !dec_s[r])                      cnt_s[r] <= cnt_s[r] + 1'b1;
        else if (dec_s[r] && !inc_s[r] && cnt_s[r] != '0) cnt_s[r] <= cnt_s[r] - 1'b1;
        if (inc_v[r] && !dec_v[r])                      cnt_v[r] <= cnt_v[r] + 1'b1;
        else if (dec_v[r] && !inc_v[r] && cnt_v[r] != '0) cnt_v[r] <= cnt_v[r] - 1'b1;
      end
      if (underflow) sb_err <= 1'b1;
    end
  end

  always_comb begin
    busy_s = '0;
    busy_v = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_s[r] = (cnt_s[r] != '0);
      busy_v[r] = (cnt_v[r] != '0);
    end
  end

endmodule
